// File: rtl/ex_issue.sv
// Execute-issue stage: 2-entry skid buffer feeding the combinational ALU.
// Define EX_FWD_EN to patch incoming and buffered operands from the writeback bypass.
module ex_issue #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RIDX = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_op,
  input  logic            in_op_imm,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [RIDX-1:0] in_rd,
  input  logic [RIDX-1:0] in_rs1,
  input  logic [RIDX-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            fwd_valid,
  input  logic [RIDX-1:0] fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            alu_op,
  output logic            alu_op_imm,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [RIDX-1:0] out_rd
);

  typedef struct packed {
    logic            op;
    logic            op_imm;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RIDX-1:0] rd;
    logic [RIDX-1:0] rs1;
    logic [RIDX-1:0] rs2;
    logic [XLEN-1:0] rs1v;
    logic [XLEN-1:0] rs2v;
    logic [XLEN-1:0] imm;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e r_state_q, w_state_d;
  entry_t r_head_q, r_skid_q;
  entry_t w_head_d, w_skid_d;
  entry_t w_in, w_in_p, w_head_p, w_skid_p;
  logic   w_accept, w_fire;

  always_comb begin
    w_in        = '0;
    w_in.op     = in_op;
    w_in.op_imm = in_op_imm;
    w_in.funct3 = in_funct3;
    w_in.funct7 = in_funct7;
    w_in.rd     = in_rd;
    w_in.rs1    = in_rs1;
    w_in.rs2    = in_rs2;
    w_in.rs1v   = in_rs1_val;
    w_in.rs2v   = in_rs2_val;
    w_in.imm    = in_imm;
  end

`ifdef EX_FWD_EN
  logic w_fwd_hit;
  assign w_fwd_hit = fwd_valid && (fwd_rd != '0);

  // Per-source match; the immediate is never touched.
  function automatic entry_t patch(entry_t e, logic hit, logic [RIDX-1:0] rd,
                                   logic [XLEN-1:0] data);
    entry_t p;
    p = e;
    if (hit && (e.rs1 == rd)) p.rs1v = data;
    if (hit && (e.rs2 == rd)) p.rs2v = data;
    return p;
  endfunction

  assign w_in_p   = patch(w_in, w_fwd_hit, fwd_rd, fwd_data);
  assign w_head_p = patch(r_head_q, w_fwd_hit, fwd_rd, fwd_data);
  assign w_skid_p = patch(r_skid_q, w_fwd_hit, fwd_rd, fwd_data);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, r_head_q.rs1, r_head_q.rs2};
  assign w_in_p   = w_in;
  assign w_head_p = r_head_q;
  assign w_skid_p = r_skid_q;
`endif

  assign w_accept = in_valid && in_ready;
  assign w_fire   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q <= StEmpty;
      r_head_q  <= '0;
      r_skid_q  <= '0;
    end else begin
      r_state_q <= w_state_d;
      r_head_q  <= w_head_d;
      r_skid_q  <= w_skid_d;
    end
  end

  always_comb begin
    w_state_d = r_state_q;
    unique case (r_state_q)
      StEmpty: if (w_accept) w_state_d = StOne;
      StOne: begin
        if (w_accept && !w_fire)      w_state_d = StTwo;
        else if (!w_accept && w_fire) w_state_d = StEmpty;
      end
      StTwo:   if (w_fire) w_state_d = StOne;
      default: w_state_d = StEmpty;
    endcase
    if (flush) w_state_d = StEmpty;
  end

  // Entries that stay put pick up bypass patches; a departing head keeps its value so
  // the outputs hold what was last presented.
  always_comb begin
    w_head_d = r_head_q;
    w_skid_d = r_skid_q;
    if (!flush) begin
      if ((r_state_q != StEmpty) && !w_fire) w_head_d = w_head_p;
      if ((r_state_q == StTwo) && !w_fire)   w_skid_d = w_skid_p;
      unique case (r_state_q)
        StEmpty: if (w_accept) w_head_d = w_in_p;
        StOne: begin
          if (w_accept && w_fire) w_head_d = w_in_p;
          else if (w_accept)      w_skid_d = w_in_p;
        end
        StTwo:   if (w_fire) w_head_d = w_skid_p;
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid  = (r_state_q != StEmpty);
    in_ready   = (r_state_q != StTwo);
    alu_op     = r_head_q.op;
    alu_op_imm = r_head_q.op_imm;
    alu_funct3 = r_head_q.funct3;
    alu_funct7 = r_head_q.funct7;
    alu_a      = r_head_q.rs1v;
    alu_b      = r_head_q.op_imm ? r_head_q.imm : r_head_q.rs2v;
    out_rd     = r_head_q.rd;
  end

endmodule

// File: doc/ex_issue.md
Name: ex_issue

Overview:
- Execute-issue stage that sits directly upstream of the ALU.
- Accepts decoded instructions with register-file operands from decode over a valid/ready handshake and buffers them in a 2-entry skid register.
- Presents a held instruction to the combinational ALU: op/op_imm/funct3/funct7 controls and the a/b operands.
- Optionally patches stale operands from the writeback bypass.

Parameters:
XLEN, 32, datapath width; ALU operands and results are XLEN bits
RIDX, 5, register index width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, synchronous, active-low
flush  in  1  drop all buffered instructions
in_valid  in  1  decode offers an instruction
in_ready  out  1  stage can accept an instruction
in_op  in  1  R-type ALU op
in_op_imm  in  1  I-type ALU op
in_funct3  in  3  funct3
in_funct7  in  7  funct7
in_rd  in  RIDX  destination register
in_rs1  in  RIDX  source 1 index
in_rs2  in  RIDX  source 2 index
in_rs1_val  in  XLEN  regfile read of rs1
in_rs2_val  in  XLEN  regfile read of rs2
in_imm  in  XLEN  sign-extended immediate
fwd_valid  in  1  writeback is writing a register this cycle
fwd_rd  in  RIDX  writeback destination
fwd_data  in  XLEN  writeback data
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes the ALU result this cycle
alu_op  out  1  head op
alu_op_imm  out  1  head op_imm
alu_funct3  out  3  head funct3
alu_funct7  out  7  head funct7
alu_a  out  XLEN  rs1 operand of head
alu_b  out  XLEN  in_imm if op_imm, else rs2 operand of head
out_rd  out  RIDX  head destination register

Behaviour:
- Storage:
  - HEAD and SKID entries, each holding the full set of fields: op, op_imm, funct3, funct7, rd, rs1, rs2, rs1v, rs2v, imm.
  - Occupancy state: EMPTY, ONE, TWO.
- Reset (rst_n=0 at a clock edge):
  - state=EMPTY, out_valid=0, in_ready=1.
  - All data outputs are 0.
  - Reset mid-operation discards both entries.
- in_ready = (state != TWO). It is a registered function of state, with no combinational path from out_ready.
- Input accept: in_valid & in_ready. Output fire: out_valid & out_ready.
- Transitions:
  - EMPTY: accept -> ONE, with the entry written to HEAD.
  - ONE:
    - accept & ~fire -> TWO, with the entry written to SKID.
    - accept & fire -> ONE, with the entry written to HEAD.
    - ~accept & fire -> EMPTY.
    - otherwise hold.
  - TWO:
    - fire -> ONE, with SKID moved to HEAD.
    - otherwise hold. No accept is possible because in_ready=0.
- Ordering: strict FIFO order; instructions are never reordered or duplicated.
- Latency: an accepted instruction appears on the outputs the cycle after acceptance when the stage was EMPTY, or when ONE with a simultaneous fire.
- Output drive:
  - out_valid = (state != EMPTY).
  - alu_* and out_rd are driven from HEAD.
  - When out_valid=0, outputs hold their last value, except after reset, when they are 0.
- Flush:
  - The next state is EMPTY regardless of accept or fire in the same cycle.
  - flush has priority over all events except reset.
- Operand select: alu_b = head.op_imm ? head.imm : head.rs2v. alu_a = head.rs1v.
- Controls: op and op_imm are passed through unchanged. When both are 0 the ALU output is don't-care; this stage does not police it.

Optional Feature:
EX_FWD_EN
- Defined:
  - In every cycle with fwd_valid=1 and fwd_rd!=0, each stored or incoming operand whose index equals fwd_rd takes fwd_data.
  - This covers incoming rs1v/rs2v on accept, and the HEAD and SKID rs1v/rs2v values.
  - The match is checked per source, so rs1 and rs2 can both match.
  - Register x0 never matches.
  - The patch also applies on the cycle an entry moves SKID->HEAD.
  - The immediate is never patched.
- Not defined:
  - fwd_* ports are ignored.
  - Operands are exactly the values presented at accept.

Test Plan:
1. Reset, then accept ADDI (op_imm=1, funct3=0, rs1v=5, imm=7, rd=3) with out_ready=1 -> next cycle out_valid=1, alu_a=5, alu_b=7, out_rd=3; following cycle out_valid=0.
2. out_ready=0 with 3 back-to-back in_valid -> first two accepted, in_ready=0 after the second. Raise out_ready -> outputs in order 1, 2, then third accepted; no loss or duplication.
3. State TWO, then assert flush together with out_ready=1 -> next cycle out_valid=0 and in_ready=1.
4. SUB (op=1, funct7=0x20, rs1v=10, rs2v=3) -> alu_b=3 and funct7=0x20 pass-through; ALU observes t=7.
5. EX_FWD_EN: HEAD has rs2=4 with rs2v=1 and is stalled; fwd_valid=1, fwd_rd=4, fwd_data=0x55 -> next cycle alu_b=0x55. With fwd_rd=0 -> unchanged. With the macro off -> unchanged.
6. Assert rst_n=0 for one cycle while in state TWO -> out_valid=0, in_ready=1, alu_a=0; the next accepted instruction is the only one issued.
